complement_serial_unit: RTL and testbench

- Parametrised, clocked successor to the team's fixed 6-bit complement logic.
- Computes pass-through, one's complement, two's complement or absolute value of a WIDTH-bit operand.
- Works bit-serially, LSB first, using a single full-adder slice plus a carry flip-flop.
- Start/busy/done handshake; sits beside the ALU datapath as a low-area negation/abs unit.

---
 rtl/complement_serial_if.sv | 22 ++
 rtl/complement_serial_unit.sv | 125 ++++++++++++
 tb/tb_complement_serial_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/complement_serial_if.sv
// Start/busy/done bus between a requester and complement_serial_unit.
// COMPLEMENT_ZERO_FLAG_EN adds the zero result flag.
interface complement_serial_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
`ifdef COMPLEMENT_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, mode, data_in, input busy, done, result, overflow, zero);
  modport slave  (input start, mode, data_in, output busy, done, result, overflow, zero);
`else
  modport master (output start, mode, data_in, input busy, done, result, overflow);
  modport slave  (input start, mode, data_in, output busy, done, result, overflow);
`endif
endinterface

// File: rtl/complement_serial_unit.sv
// Bit-serial pass / one's complement / two's complement / abs unit, LSB first.
// Optional macro COMPLEMENT_ZERO_FLAG_EN adds a serially accumulated zero flag.
module complement_serial_unit #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  complement_serial_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic                     accept;
  logic [WIDTH-1:0]         sh_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     carry_q;
  logic                     inv_q;
  logic                     ovf_pend_q;
  logic signed [WIDTH-1:0]  operand_s;
  logic                     neg;
  logic                     inv;
  logic                     bit_b;
  logic                     out_bit;
  logic [WIDTH-1:0]         sh_next;
  logic                     last_bit;

  function automatic logic is_most_neg(input logic [WIDTH-1:0] x);
    return x == {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  assign operand_s = signed'(bus.data_in);
  assign neg       = (bus.mode == 2'b10) | ((bus.mode == 2'b11) & (operand_s < 0));
  assign inv       = (bus.mode == 2'b01) | neg;

  // Single full-adder slice: invert-and-add-carry, one bit per clock
  assign bit_b    = sh_q[0] ^ inv_q;
  assign out_bit  = bit_b ^ carry_q;
  assign sh_next  = {out_bit, sh_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q         <= '0;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      inv_q        <= 1'b0;
      ovf_pend_q   <= 1'b0;
      bus.result   <= '0;
      bus.overflow <= 1'b0;
    end else if (accept) begin
      sh_q       <= bus.data_in;
      cnt_q      <= '0;
      carry_q    <= neg;
      inv_q      <= inv;
      ovf_pend_q <= neg & is_most_neg(bus.data_in);
    end else if (state_q == RUN) begin
      sh_q    <= sh_next;
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= bit_b & carry_q;
      if (last_bit) begin
        bus.result   <= sh_next;
        bus.overflow <= ovf_pend_q;
      end
    end
  end

`ifdef COMPLEMENT_ZERO_FLAG_EN
  logic acc_q;

  // OR of every out bit seen so far; zero is its complement at the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 1'b0;
      bus.zero <= 1'b0;
    end else if (accept) begin
      acc_q <= 1'b0;
    end else if (state_q == RUN) begin
      acc_q <= acc_q | out_bit;
      if (last_bit) bus.zero <= ~(acc_q | out_bit);
    end
  end
`endif

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_complement_serial_unit.sv
// Scoreboard bench for complement_serial_unit: 6-bit and 8-bit instances,
// directed cases plus random operations checked against an arithmetic model.
module tb_complement_serial_unit;

  logic clk;
  logic rst_n;

  complement_serial_if #(.WIDTH(6)) if6 ();
  complement_serial_if #(.WIDTH(8)) if8 ();

  complement_serial_unit #(.WIDTH(6), .CNT_W(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));
  complement_serial_unit #(.WIDTH(8), .CNT_W(6)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t q6[$];
  exp_t q8[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic prev_done6 = 1'b0;
  logic prev_done8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operand as signed integer, apply the operation exactly,
  // then flag results that do not fit in w signed bits and wrap modulo 2^w.
  function automatic logic [32:0] model(input int w, input logic [1:0] m, input logic [31:0] x);
    longint lim, v, t;
    logic   ovf;
    lim = longint'(1) << (w - 1);
    v   = longint'(x) & (2 * lim - 1);
    if (x[w-1]) v = v - 2 * lim;
    case (m)
      2'b00:   t = v;
      2'b01:   t = -v - 1;
      2'b10:   t = -v;
      default: t = (v < 0) ? -v : v;
    endcase
    ovf = (t >= lim) || (t < -lim);
    return {ovf, 32'(t & (2 * lim - 1))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until the selected unit can accept, then present one start cycle.
  task automatic issue(input int inst, input logic [1:0] m, input logic [31:0] x,
                       input logic [31:0] exp_res, input logic exp_ovf);
    int   n = 0;
    exp_t e;
    while (((inst == 6) ? if6.busy : if8.busy) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      check("issue_wait_timeout", 32'(n), 32'd0);
      return;
    end
    if (inst == 6) begin
      if6.start = 1'b1; if6.mode = m; if6.data_in = x[5:0];
    end else begin
      if8.start = 1'b1; if8.mode = m; if8.data_in = x[7:0];
    end
    tick();
    e.res = exp_res;
    e.ovf = exp_ovf;
    e.acc_cyc = cyc;
    if (inst == 6) begin
      q6.push_back(e);
      if6.start = 1'b0; if6.mode = 2'($urandom); if6.data_in = 6'($urandom);
    end else begin
      q8.push_back(e);
      if8.start = 1'b0; if8.mode = 2'($urandom); if8.data_in = 8'($urandom);
    end
  endtask

  task automatic issue_model(input int inst, input logic [1:0] m, input logic [31:0] x);
    logic [32:0] r;
    r = model(inst, m, x);
    issue(inst, m, x, r[31:0], r[32]);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 1;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return mask;
      3:       return 32'd1;
      default: return $urandom & mask;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if6.done) begin
        check("done6_single_cycle", 32'(prev_done6), 32'd0);
        if (q6.size() == 0) begin
          check("done6_unexpected", 32'd1, 32'd0);
        end else begin
          e = q6.pop_front();
          check("result6", 32'(if6.result), e.res);
          check("overflow6", 32'(if6.overflow), 32'(e.ovf));
          check("latency6", 32'(cyc - e.acc_cyc), 32'd6);
`ifdef COMPLEMENT_ZERO_FLAG_EN
          check("zero6", 32'(if6.zero), 32'(e.res == 32'd0));
`endif
        end
      end
      if (if8.done) begin
        check("done8_single_cycle", 32'(prev_done8), 32'd0);
        if (q8.size() == 0) begin
          check("done8_unexpected", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          check("result8", 32'(if8.result), e.res);
          check("overflow8", 32'(if8.overflow), 32'(e.ovf));
          check("latency8", 32'(cyc - e.acc_cyc), 32'd8);
`ifdef COMPLEMENT_ZERO_FLAG_EN
          check("zero8", 32'(if8.zero), 32'(e.res == 32'd0));
`endif
        end
      end
    end
    prev_done6 = if6.done;
    prev_done8 = if8.done;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy6"}, 32'(if6.busy), 32'd0);
    check({tag, "_done6"}, 32'(if6.done), 32'd0);
    check({tag, "_result6"}, 32'(if6.result), 32'd0);
    check({tag, "_overflow6"}, 32'(if6.overflow), 32'd0);
    check({tag, "_busy8"}, 32'(if8.busy), 32'd0);
    check({tag, "_result8"}, 32'(if8.result), 32'd0);
`ifdef COMPLEMENT_ZERO_FLAG_EN
    check({tag, "_zero6"}, 32'(if6.zero), 32'd0);
`endif
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    if6.start = 1'b0; if6.mode = 2'b00; if6.data_in = '0;
    if8.start = 1'b0; if8.mode = 2'b00; if8.data_in = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Directed cases on the 6-bit unit
    issue(6, 2'b10, 32'b000001, 32'b111111, 1'b0);
    issue(6, 2'b01, 32'b100011, 32'b011100, 1'b0);
    issue(6, 2'b00, 32'b101010, 32'b101010, 1'b0);
    issue(6, 2'b10, 32'b100000, 32'b100000, 1'b1);
    issue(6, 2'b10, 32'b000000, 32'b000000, 1'b0);
    issue(6, 2'b11, 32'b001010, 32'b001010, 1'b0);
    issue(6, 2'b11, 32'b111101, 32'b000011, 1'b0);

    // A start during RUN must be ignored
    tick();
    if6.start = 1'b1; if6.mode = 2'b10; if6.data_in = 6'b000111;
    tick();
    if6.start = 1'b0;

    // Reset in the middle of an operation discards it
    issue(6, 2'b10, 32'b010101, 32'b101011, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    q6.delete();
    #1;
    check_reset_outputs("midrun_reset");
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    issue(6, 2'b10, 32'b000011, 32'b111101, 1'b0);

    // 8-bit unit, including a back-to-back accept from DONE
    issue(8, 2'b11, 32'h80, 32'h80, 1'b1);
    issue(8, 2'b11, 32'hFF, 32'h01, 1'b0);

    // Random operations on both widths
    for (int i = 0; i < 40; i++) begin
      issue_model(6, 2'($urandom), pick(6));
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < 25; i++) begin
      issue_model(8, 2'($urandom), pick(8));
      repeat ($urandom_range(0, 2)) tick();
    end

    n = 0;
    while ((q6.size() != 0 || q8.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(q6.size() + q8.size()), 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared expected completion", compared);
    $fatal(1, "watchdog");
  end

endmodule
